// File: rtl/mem_access_pkg.sv
// Shared CPU properties for the data-memory access stage: default widths,
// funct3 size codes, FSM state encoding and small size/alignment helpers.
package mem_access_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  // Any funct3 that is not a byte or half code is handled as a full word.
  function automatic size_t size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_H:    is_misaligned = lo[0];
      SZ_W:    is_misaligned = |lo;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    byte_enable = 4'b0001 << lo;
      SZ_H:    byte_enable = 4'b0011 << lo;
      default: byte_enable = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/load_align.sv
// Load return lane select: picks the addressed byte/half from the memory
// word and sign- or zero-extends it to the full datapath width.
module load_align
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [2:0]            funct3,
  input  logic [1:0]            byte_off,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] shifted;
  logic                  is_unsigned;

  // Shift the addressed lane down to bit 0, then extend per size and sign.
  always_comb begin
    shifted     = rdata >> {byte_off, 3'b000};
    is_unsigned = funct3[2];
    case (size_of(funct3))
      SZ_B: begin
        if (is_unsigned) data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
        else             data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      end
      SZ_H: begin
        if (is_unsigned) data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
        else             data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      end
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results through, issues aligned
// load/store requests with a req/gnt/rvalid handshake, and registers the
// writeback result.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH          = DATA_WIDTH_DEF,
  parameter int REG_FILE_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           _rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_is_load,
  input  logic                           in_is_store,
  input  logic [2:0]                     in_funct3,
  input  logic [DATA_WIDTH-1:0]          in_addr,
  input  logic [DATA_WIDTH-1:0]          in_wdata,
  input  logic [REG_FILE_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic                           in_reg_w_en,
  output logic                           dmem_req,
  output logic                           dmem_we,
  output logic [DATA_WIDTH-1:0]          dmem_addr,
  output logic [3:0]                     dmem_be,
  output logic [DATA_WIDTH-1:0]          dmem_wdata,
  input  logic                           dmem_gnt,
  input  logic                           dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]          dmem_rdata,
  output logic                           reg_w_en_out,
  output logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr_out,
  output logic [DATA_WIDTH-1:0]          reg_data_out,
  output logic                           misalign
);

  state_t                         state;
  logic [2:0]                     cap_funct3;
  logic [1:0]                     cap_off;
  logic [REG_FILE_ADDR_WIDTH-1:0] cap_rd;
  logic                           cap_w_en;
  logic                           cap_is_load;

  size_t                          req_size;
  logic                           req_misaligned;
  logic                           is_mem;
  logic [3:0]                     req_be;
  logic [DATA_WIDTH-1:0]          req_wdata;
  logic [DATA_WIDTH-1:0]          load_data;

  assign in_ready = (state == ST_IDLE);

  // Decode the incoming op: size, alignment, byte enables and lane-replicated store data.
  always_comb begin
    is_mem         = in_is_load | in_is_store;
    req_size       = size_of(in_funct3);
    req_misaligned = is_misaligned(req_size, in_addr[1:0]);
    req_be         = byte_enable(req_size, in_addr[1:0]);
    case (req_size)
      SZ_B:    req_wdata = {(DATA_WIDTH/8){in_wdata[7:0]}};
      SZ_H:    req_wdata = {(DATA_WIDTH/16){in_wdata[15:0]}};
      default: req_wdata = in_wdata;
    endcase
  end

  load_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_align (
    .rdata    (dmem_rdata),
    .funct3   (cap_funct3),
    .byte_off (cap_off),
    .data     (load_data)
  );

  // Access FSM with registered memory-request and writeback outputs.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state        <= ST_IDLE;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= {DATA_WIDTH{1'b0}};
      dmem_be      <= 4'b0000;
      dmem_wdata   <= {DATA_WIDTH{1'b0}};
      reg_w_en_out <= 1'b0;
      rd_addr_out  <= {REG_FILE_ADDR_WIDTH{1'b0}};
      reg_data_out <= {DATA_WIDTH{1'b0}};
      misalign     <= 1'b0;
      cap_funct3   <= 3'b000;
      cap_off      <= 2'b00;
      cap_rd       <= {REG_FILE_ADDR_WIDTH{1'b0}};
      cap_w_en     <= 1'b0;
      cap_is_load  <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!in_valid) begin
            reg_w_en_out <= 1'b0;
          end else if (!is_mem) begin
            reg_w_en_out <= in_reg_w_en && (in_rd_addr != {REG_FILE_ADDR_WIDTH{1'b0}});
            rd_addr_out  <= in_rd_addr;
            reg_data_out <= in_addr;
          end else if (req_misaligned) begin
            misalign     <= 1'b1;
            reg_w_en_out <= 1'b0;
          end else begin
            cap_funct3   <= in_funct3;
            cap_off      <= in_addr[1:0];
            cap_rd       <= in_rd_addr;
            cap_w_en     <= in_reg_w_en;
            cap_is_load  <= in_is_load;
            dmem_req     <= 1'b1;
            dmem_we      <= in_is_store;
            dmem_addr    <= {in_addr[DATA_WIDTH-1:2], 2'b00};
            dmem_be      <= req_be;
            dmem_wdata   <= req_wdata;
            reg_w_en_out <= 1'b0;
            state        <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (cap_is_load) state <= ST_WAIT;
            else             state <= ST_IDLE;
          end else begin
            state <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (dmem_rvalid) begin
            reg_data_out <= load_data;
            reg_w_en_out <= cap_w_en && (cap_rd != {REG_FILE_ADDR_WIDTH{1'b0}});
            rd_addr_out  <= cap_rd;
            state        <= ST_IDLE;
          end else begin
            state <= ST_WAIT;
          end
        end
        default: begin
          state    <= ST_IDLE;
          dmem_req <= 1'b0;
          dmem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// ops checked against an arithmetic reference model of sizes and lanes.
module tb_mem_access;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic [4:0]  in_rd_addr;
  logic        in_reg_w_en;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        reg_w_en_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] reg_data_out;
  logic        misalign;

  int n_cmp = 0;
  int n_err = 0;

  mem_access dut (
    .clk          (clk),
    ._rst         (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_is_load   (in_is_load),
    .in_is_store  (in_is_store),
    .in_funct3    (in_funct3),
    .in_addr      (in_addr),
    .in_wdata     (in_wdata),
    .in_rd_addr   (in_rd_addr),
    .in_reg_w_en  (in_reg_w_en),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_gnt     (dmem_gnt),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .reg_w_en_out (reg_w_en_out),
    .rd_addr_out  (rd_addr_out),
    .reg_data_out (reg_data_out),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Access size in bytes; anything that is not a B/H code is a word.
  function automatic int size_bytes(input logic [2:0] f3);
    if (f3 == 3'b000 || f3 == 3'b100) return 1;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    int off;
    sz  = size_bytes(f3);
    off = int'(addr % 32'd4);
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = size_bytes(f3);
    if (sz == 1) return (wd % 32'd256) * 32'h0101_0101;
    if (sz == 2) return (wd % 32'd65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int      sz;
    longint  v;
    longint  span;
    sz = size_bytes(f3);
    if (sz == 4) return rd;
    span = longint'(1) << (8 * sz);
    v = (longint'(rd) >> (8 * int'(addr % 32'd4))) % span;
    if (f3[2] == 1'b0 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  // ---------------- drivers ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
    in_addr = 32'h0; in_wdata = 32'h0; in_rd_addr = 5'd0; in_reg_w_en = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
  endtask

  task automatic do_alu_op(input logic [31:0] val, input logic [4:0] rd, input bit wen);
    logic exp_wen;
    exp_wen = wen && (rd != 5'd0);
    in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'($urandom_range(0, 7));
    in_addr = val; in_rd_addr = rd; in_reg_w_en = wen; in_wdata = $urandom;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (reg_data_out !== val) begin n_err++; $display("FAIL alu_data: got %h want %h", reg_data_out, val); end
    n_cmp++; if (rd_addr_out !== rd) begin n_err++; $display("FAIL alu_rd: got %0d want %0d", rd_addr_out, rd); end
    n_cmp++; if (reg_w_en_out !== exp_wen) begin n_err++; $display("FAIL alu_wen: got %b want %b", reg_w_en_out, exp_wen); end
    n_cmp++; if (in_ready !== 1'b1 || dmem_req !== 1'b0) begin n_err++; $display("FAIL alu_ready: ready %b req %b want 1 0", in_ready, dmem_req); end
  endtask

  // One load/store through the full handshake with gw grant-wait cycles and
  // rw extra cycles before rvalid; stray rvalid is driven while waiting for gnt.
  task automatic do_mem_op(input bit ld, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd, input bit wen,
                           input int gw, input int rw, input logic [31:0] rdata, input bit stray);
    int          sz;
    logic [31:0] e_addr, e_wd, e_ld;
    logic [3:0]  e_be;
    logic        e_wen;
    sz     = size_bytes(f3);
    e_addr = addr - (addr % 32'd4);
    e_be   = model_be(f3, addr);
    e_wd   = model_wdata(f3, wdata);
    e_ld   = model_load(f3, addr, rdata);
    e_wen  = wen && (rd != 5'd0);
    in_valid = 1'b1; in_is_load = ld; in_is_store = !ld; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_rd_addr = rd; in_reg_w_en = wen;
    tick;
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
    if (addr % sz != 0) begin
      n_cmp++; if (misalign !== 1'b1) begin n_err++; $display("FAIL mis_pulse: got %b want 1 (addr %h f3 %b)", misalign, addr, f3); end
      n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_noreq: got %b want 0", dmem_req); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mis_ready: got %b want 1", in_ready); end
      n_cmp++; if (reg_w_en_out !== 1'b0) begin n_err++; $display("FAIL mis_wen: got %b want 0", reg_w_en_out); end
      tick;
      n_cmp++; if (misalign !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL mis_end: misalign %b req %b want 0 0", misalign, dmem_req); end
      return;
    end
    for (int i = 0; i <= gw; i++) begin
      n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== !ld) begin n_err++; $display("FAIL req_ctl: req %b we %b want 1 %b", dmem_req, dmem_we, !ld); end
      n_cmp++; if (dmem_addr !== e_addr) begin n_err++; $display("FAIL req_addr: got %h want %h", dmem_addr, e_addr); end
      n_cmp++; if (dmem_be !== e_be) begin n_err++; $display("FAIL req_be: got %b want %b", dmem_be, e_be); end
      if (!ld) begin
        n_cmp++; if (dmem_wdata !== e_wd) begin n_err++; $display("FAIL req_wdata: got %h want %h", dmem_wdata, e_wd); end
      end
      n_cmp++; if (in_ready !== 1'b0 || reg_w_en_out !== 1'b0) begin n_err++; $display("FAIL req_busy: ready %b wen %b want 0 0", in_ready, reg_w_en_out); end
      if (i < gw) begin
        dmem_rvalid = stray; dmem_rdata = $urandom;
        tick;
        dmem_rvalid = 1'b0;
      end
    end
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL gnt_drop: req %b want 0", dmem_req); end
    if (!ld) begin
      n_cmp++; if (in_ready !== 1'b1 || reg_w_en_out !== 1'b0) begin n_err++; $display("FAIL st_done: ready %b wen %b want 1 0", in_ready, reg_w_en_out); end
      return;
    end
    for (int i = 0; i < rw; i++) begin
      tick;
      n_cmp++; if (in_ready !== 1'b0 || reg_w_en_out !== 1'b0) begin n_err++; $display("FAIL wait_busy: ready %b wen %b want 0 0", in_ready, reg_w_en_out); end
    end
    dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick;
    dmem_rvalid = 1'b0;
    n_cmp++; if (reg_data_out !== e_ld) begin n_err++; $display("FAIL ld_data: got %h want %h (f3 %b addr %h rdata %h)", reg_data_out, e_ld, f3, addr, rdata); end
    n_cmp++; if (reg_w_en_out !== e_wen) begin n_err++; $display("FAIL ld_wen: got %b want %b", reg_w_en_out, e_wen); end
    n_cmp++; if (rd_addr_out !== rd) begin n_err++; $display("FAIL ld_rd: got %0d want %0d", rd_addr_out, rd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ld_ready: got %b want 1", in_ready); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    n_cmp++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin n_err++; $display("FAIL rst_req: req %b we %b want 0 0", dmem_req, dmem_we); end
    n_cmp++; if (reg_w_en_out !== 1'b0 || rd_addr_out !== 5'd0 || reg_data_out !== 32'h0) begin n_err++; $display("FAIL rst_wb: wen %b rd %0d data %h want 0", reg_w_en_out, rd_addr_out, reg_data_out); end
    n_cmp++; if (misalign !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rst_misc: misalign %b ready %b want 0 1", misalign, in_ready); end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_alu;
    do_alu_op(32'h0000_1234, 5'd5, 1'b1);
    n_cmp++; if (reg_data_out !== 32'h0000_1234 || rd_addr_out !== 5'd5 || reg_w_en_out !== 1'b1) begin n_err++; $display("FAIL alu_directed: data %h rd %0d wen %b want 00001234 5 1", reg_data_out, rd_addr_out, reg_w_en_out); end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick;
    dmem_rvalid = 1'b0;
    n_cmp++; if (reg_w_en_out !== 1'b0 || reg_data_out !== 32'h0000_1234 || rd_addr_out !== 5'd5) begin n_err++; $display("FAIL idle_hold: wen %b data %h rd %0d want 0 00001234 5", reg_w_en_out, reg_data_out, rd_addr_out); end
    do_alu_op(32'hCAFE_0001, 5'd0, 1'b1);
    do_alu_op(32'h7777_8888, 5'd31, 1'b0);
  endtask

  task automatic test_load_byte;
    do_mem_op(1'b1, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 0, 32'h80FF_FFFF, 1'b1);
    n_cmp++; if (reg_data_out !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_directed: got %h want ffffff80", reg_data_out); end
    tick;
    do_mem_op(1'b1, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1'b1, 2, 1, 32'h80FF_FFFF, 1'b0);
    n_cmp++; if (reg_data_out !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_directed: got %h want 00000080", reg_data_out); end
    tick;
  endtask

  task automatic test_store_half;
    in_valid = 1'b1; in_is_store = 1'b1; in_funct3 = 3'b001; in_addr = 32'h0000_0202;
    in_wdata = 32'h0000_ABCD; in_rd_addr = 5'd3; in_reg_w_en = 1'b0;
    tick;
    in_valid = 1'b0; in_is_store = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h0000_0200 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD) begin
        n_err++; $display("FAIL sh_directed: req %b we %b addr %h be %b wd %h want 1 1 00000200 1100 abcdabcd", dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
      end
      tick;
    end
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    n_cmp++; if (dmem_req !== 1'b0 || reg_w_en_out !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL sh_done: req %b wen %b ready %b want 0 0 1", dmem_req, reg_w_en_out, in_ready); end
    do_mem_op(1'b0, 3'b000, 32'h0000_0301, 32'h1234_56A5, 5'd0, 1'b0, 1, 0, 32'h0, 1'b0);
  endtask

  task automatic test_misalign;
    do_mem_op(1'b1, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 1'b1, 0, 0, 32'h0, 1'b0);
    do_mem_op(1'b0, 3'b001, 32'h0000_0203, 32'h5555, 5'd0, 1'b0, 0, 0, 32'h0, 1'b0);
    do_mem_op(1'b1, 3'b101, 32'h0000_0001, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0, 1'b0);
    do_mem_op(1'b1, 3'b111, 32'h0000_0402, 32'h0, 5'd4, 1'b1, 0, 0, 32'h0, 1'b0);
  endtask

  task automatic test_rd_zero;
    do_mem_op(1'b1, 3'b010, 32'h0000_0400, 32'h0, 5'd0, 1'b1, 0, 0, 32'h1234_5678, 1'b0);
    n_cmp++; if (reg_w_en_out !== 1'b0 || reg_data_out !== 32'h1234_5678) begin n_err++; $display("FAIL rd0: wen %b data %h want 0 12345678", reg_w_en_out, reg_data_out); end
    tick;
  endtask

  task automatic test_reset_mid;
    do_alu_op(32'hA5A5_5A5A, 5'd12, 1'b1);
    in_valid = 1'b1; in_is_load = 1'b1; in_funct3 = 3'b010; in_addr = 32'h0000_0800;
    in_rd_addr = 5'd6; in_reg_w_en = 1'b1;
    tick;
    in_valid = 1'b0; in_is_load = 1'b0;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dmem_req !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_req: req %b ready %b want 0 1", dmem_req, in_ready); end
    n_cmp++; if (reg_w_en_out !== 1'b0 || rd_addr_out !== 5'd0 || reg_data_out !== 32'h0 || misalign !== 1'b0) begin n_err++; $display("FAIL rstmid_out: wen %b rd %0d data %h mis %b want 0", reg_w_en_out, rd_addr_out, reg_data_out, misalign); end
    tick;
    #2 rst_n = 1'b1;
    tick;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick;
    dmem_rvalid = 1'b0;
    n_cmp++; if (reg_w_en_out !== 1'b0 || reg_data_out !== 32'h0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_stray: wen %b data %h ready %b want 0 0 1", reg_w_en_out, reg_data_out, in_ready); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        do_alu_op($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      end else begin
        do_mem_op(kind == 1, 3'($urandom_range(0, 7)), $urandom, $urandom,
                  5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3), $urandom_range(0, 2), $urandom, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) tick;
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_rd_zero();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
